pixel_scan_gen: RTL and testbench
=================================

# pixel_scan_gen

Raster scan initiator for the 640x480 game display. It drives the 19-bit pixel `address` stream that the square-overlay renderer and palette path consume, and captures the returned 8-bit colour index. It also delays sync and blanking so they line up with that returned index, and emits a once-per-frame tick for the game-state logic. It sits between the board renderer (upstream data) and the VGA DAC/colour lookup (downstream).

## Interface
Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch
- `H_SYNC`, 96, hsync width
- `H_BACK`, 48, horizontal back porch
- `V_VISIBLE`, 480, active lines
- `V_FRONT`, 10, vertical front porch
- `V_SYNC`, 2, vsync width
- `V_BACK`, 33, vertical back porch
- `PIPE_LAT`, 2, number of pix_en ticks from `address` to a valid `qin` (range 1..4)

Ports:
- `clk` in 1: system clock
- `resetn` in 1: asynchronous, active-low reset
- `pix_en` in 1: pixel-rate enable; all scan state advances only on cycles where `pix_en`=1
- `address` out 19: linear pixel address, v*640+h
- `addr_valid` out 1: high when `address` is a visible pixel
- `qin` in 8: colour index returned by the render chain, `PIPE_LAT` ticks after `address`
- `pixel_idx` out 8: aligned colour index for the DAC, 0 during blanking
- `hsync` out 1: active-low, aligned with `pixel_idx`
- `vsync` out 1: active-low, aligned with `pixel_idx`
- `blank_n` out 1: high on visible pixels, aligned with `pixel_idx`
- `frame_tick` out 1: single-`clk` pulse at frame wrap

## Operation
- Counters: h runs 0..H_TOTAL-1 (H_TOTAL=800) and v runs 0..V_TOTAL-1 (V_TOTAL=525).
  - h increments on each `pix_en`.
  - When h wraps to 0, v increments.
  - When v=524 and h=799, both counters go to 0.
- Visible pixel: h<640 and v<480.
- `address` is maintained incrementally, with no multiplier.
  - It increments by 1 on each visible tick.
  - It holds its value through horizontal blanking, so the next line resumes at v*640.
  - It returns to 0 on frame wrap.
  - It must therefore equal v*640+h on every visible pixel.
  - During blanking its value is don't-care, but it must be held constant.
- `addr_valid` is registered alongside the counters (visible flag of the current h,v).
- Raw sync decode:
  - hsync_raw=0 when 656<=h<=751.
  - vsync_raw=0 when 490<=v<=491.
  - blank_raw=addr_valid.
- Alignment: hsync_raw, vsync_raw and blank_raw pass through a `PIPE_LAT`-deep shift register that advances on `pix_en`.
- On each `pix_en` tick, `pixel_idx` is registered as `qin` when the delayed blank is high, else 8'h00.
- `frame_tick` pulses for exactly one `clk` cycle, on the edge where the counters wrap to (0,0).
- With `pix_en`=0, every register holds its value and `frame_tick` stays 0.

## Timing
- Reset values (asynchronous, on `resetn`=0):
  - h, v, `address`: 0
  - `addr_valid`: 0
  - shift-register stages: hsync=1, vsync=1, blank=0
  - `hsync`: 1; `vsync`: 1; `blank_n`: 0
  - `pixel_idx`: 8'h00; `frame_tick`: 0
- First tick after reset release: counters stay at (0,0) and `addr_valid` becomes 1. This first tick is the presentation of pixel 0.
- Latency:
  - The `address` of pixel N is presented on tick T.
  - `qin` for pixel N is sampled on tick T+PIPE_LAT.
  - `pixel_idx`, `hsync`, `vsync` and `blank_n` for pixel N become visible after that edge.
- Line period is 800 ticks; frame period is 420000 ticks.
- Reset mid-frame: all outputs return to their reset values immediately. The pipeline is flushed, so no stale `qin` is forwarded. The scan restarts at (0,0).
- `pix_en` held high continuously is legal (1 pixel per `clk`).

## Test plan
- Reset: assert `resetn`=0 mid-line. Required: `hsync`=1, `vsync`=1, `blank_n`=0, `pixel_idx`=0, `address`=0 in the same cycle, before the next edge.
- Line 0 scan (`pix_en`=1 every cycle): `address` steps 0..639 with `addr_valid`=1. For ticks 640..799, `addr_valid`=0 and `address` holds. Line 1 begins at `address`=640.
- Sync placement: `hsync` is low for exactly 96 ticks, starting 656+PIPE_LAT ticks after line start. `vsync` is low for exactly 2 lines, lines 490..491 (delayed by PIPE_LAT).
- Alignment: use a bench model with `qin`=address[7:0] delayed by PIPE_LAT=2.
  - `pixel_idx` sequence must be 0x00,0x01,... on the first `blank_n`=1 cycles.
  - `pixel_idx` must be 0x00 whenever `blank_n`=0.
  - The last visible pixel (`address`=307199) must yield 0xFF.
- Frame wrap: after 420000 ticks, `frame_tick` is high for one `clk`. The next `address` is 0. Only one pulse occurs per frame.
- `pix_en` stall: toggle `pix_en` 1,0,1,0. Required: counters and outputs change only on enabled cycles, and `frame_tick` is never asserted on a `pix_en`=0 cycle.

Source files
------------

// File: rtl/pixel_scan_gen.sv
// Raster scan initiator: walks h/v counters, streams linear pixel addresses, and
// re-aligns sync/blank with the colour index returned by the render chain.
module pixel_scan_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIPE_LAT  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pix_en,
  output logic [18:0] address,
  output logic        addr_valid,
  input  logic [7:0]  qin,
  output logic [7:0]  pixel_idx,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic          started;
  logic          wrap;
  logic          vis_nxt;
  logic [18:0]   addr_nxt;

  logic          hs_raw, vs_raw;
  logic [PIPE_LAT:1]   hs_sr, vs_sr, bl_sr;
  logic [PIPE_LAT-1:0] bl_tap;

  // The first enabled tick after reset only presents pixel (0,0); counting starts after it.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    wrap  = 1'b0;
    if (started) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        if (v_cnt == V_LAST) begin
          v_nxt = '0;
          wrap  = 1'b1;
        end else begin
          v_nxt = v_cnt + VW'(1);
        end
      end else begin
        h_nxt = h_cnt + HW'(1);
      end
    end
  end

  assign vis_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);

  // Stepping only off visible pixels leaves the address parked at the next line's base.
  assign addr_nxt = wrap ? 19'd0 : address + {18'd0, addr_valid};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      started    <= 1'b0;
      address    <= 19'd0;
      addr_valid <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_en & wrap;
      if (pix_en) begin
        started    <= 1'b1;
        h_cnt      <= h_nxt;
        v_cnt      <= v_nxt;
        address    <= addr_nxt;
        addr_valid <= vis_nxt;
      end
    end
  end

  assign hs_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));

  // Tap 0 is the undelayed blank; tap k is shift stage k.
  always_comb begin
    bl_tap    = '0;
    bl_tap[0] = addr_valid;
    for (int i = 1; i < PIPE_LAT; i++) bl_tap[i] = bl_sr[i];
  end

  // Final stage drives the sync/blank outputs; pixel_idx is captured on the same tick
  // from the stage before it, so all four outputs describe the same pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hs_sr     <= '1;
      vs_sr     <= '1;
      bl_sr     <= '0;
      pixel_idx <= 8'h00;
    end else if (pix_en) begin
      hs_sr[1] <= hs_raw;
      vs_sr[1] <= vs_raw;
      bl_sr[1] <= addr_valid;
      for (int i = 2; i <= PIPE_LAT; i++) begin
        hs_sr[i] <= hs_sr[i-1];
        vs_sr[i] <= vs_sr[i-1];
        bl_sr[i] <= bl_sr[i-1];
      end
      pixel_idx <= bl_tap[PIPE_LAT-1] ? qin : 8'h00;
    end
  end

  assign hsync   = hs_sr[PIPE_LAT];
  assign vsync   = vs_sr[PIPE_LAT];
  assign blank_n = bl_sr[PIPE_LAT];

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Bench for pixel_scan_gen on a shrunken raster so several frames fit in a short run;
// a reference scan model fills an expected-output queue drained as the DUT responds.
module tb_pixel_scan_gen;

  localparam int HV = 16, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 1;
  localparam int PL = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [10:0] RESET_OUT = {1'b1, 1'b1, 1'b0, 8'h00};

  logic        clk = 1'b0;
  logic        resetn;
  logic        pix_en;
  logic [18:0] address;
  logic        addr_valid;
  logic [7:0]  qin;
  logic [7:0]  pixel_idx;
  logic        hsync, vsync, blank_n, frame_tick;

  pixel_scan_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIPE_LAT(PL)
  ) dut (
    .clk(clk), .resetn(resetn), .pix_en(pix_en),
    .address(address), .addr_valid(addr_valid), .qin(qin),
    .pixel_idx(pixel_idx), .hsync(hsync), .vsync(vsync),
    .blank_n(blank_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // reference scan model
  int          m_h, m_v, m_addr;
  bit          m_started, m_valid, m_ft;
  logic [10:0] exp_q[$];
  logic [10:0] last_out;
  logic [18:0] rd [0:PL-2];
  logic [18:0] prev_addr;
  bit          prev_vis;
  int          hrun, vrun;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_addr = 0;
    m_started = 0; m_valid = 0; m_ft = 0;
    exp_q.delete();
    for (int i = 0; i < PL; i++) exp_q.push_back(RESET_OUT);
    last_out = RESET_OUT;
    for (int i = 0; i < PL - 1; i++) rd[i] = '0;
    qin = 8'h00;
    prev_addr = '0; prev_vis = 0;
    hrun = 0; vrun = 0;
  endtask

  task automatic model_step();
    logic hs_e, vs_e;
    logic [7:0] pix_e;
    if (!m_started) begin
      m_started = 1;
    end else if (m_h == HT - 1) begin
      m_h = 0;
      if (m_v == VT - 1) begin
        m_v = 0;
        m_ft = 1;
      end else begin
        m_v++;
      end
    end else begin
      m_h++;
    end
    m_valid = (m_h < HV) && (m_v < VV);
    m_addr  = m_v * HV + m_h;
    hs_e  = !((m_h >= HV + HF) && (m_h < HV + HF + HS));
    vs_e  = !((m_v >= VV + VF) && (m_v < VV + VF + VS));
    pix_e = m_valid ? m_addr[7:0] : 8'h00;
    exp_q.push_back({hs_e, vs_e, m_valid, pix_e});
  endtask

  task automatic tick(input logic en);
    logic [18:0] pre;
    pix_en = en;
    pre = address;
    @(posedge clk);
    #1;
    m_ft = 0;
    if (en) begin
      // render chain: return address[7:0] PL ticks after it was presented
      for (int i = PL - 2; i > 0; i--) rd[i] = rd[i-1];
      rd[0] = pre;
      qin = rd[PL-2][7:0];
      if (exp_q.size() == 0) check_val("sb_empty", 32'd1, 32'd0);
      else last_out = exp_q.pop_front();
      model_step();
    end
    check_val("addr_valid", {31'd0, addr_valid}, {31'd0, m_valid});
    if (m_valid) check_val("address", {13'd0, address}, m_addr);
    else if (!prev_vis) check_val("addr_hold", {13'd0, address}, {13'd0, prev_addr});
    check_val("hsync", {31'd0, hsync}, {31'd0, last_out[10]});
    check_val("vsync", {31'd0, vsync}, {31'd0, last_out[9]});
    check_val("blank_n", {31'd0, blank_n}, {31'd0, last_out[8]});
    check_val("pixel_idx", {24'd0, pixel_idx}, {24'd0, last_out[7:0]});
    check_val("frame_tick", {31'd0, frame_tick}, {31'd0, m_ft});
    if (en) begin
      if (!hsync) hrun++;
      else if (hrun > 0) begin
        check_val("hsync_width", hrun, HS);
        hrun = 0;
      end
      if (!vsync) vrun++;
      else if (vrun > 0) begin
        check_val("vsync_width", vrun, VS * HT);
        vrun = 0;
      end
    end
    prev_addr = address;
    prev_vis  = m_valid;
  endtask

  task automatic async_reset();
    #2;
    resetn = 1'b0;
    #1;
    check_val("rst_hsync", {31'd0, hsync}, 32'd1);
    check_val("rst_vsync", {31'd0, vsync}, 32'd1);
    check_val("rst_blank_n", {31'd0, blank_n}, 32'd0);
    check_val("rst_pixel_idx", {24'd0, pixel_idx}, 32'd0);
    check_val("rst_address", {13'd0, address}, 32'd0);
    check_val("rst_addr_valid", {31'd0, addr_valid}, 32'd0);
    check_val("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    pix_en = 1'b0;
    model_reset();
    repeat (3) tick(1'b0);
    resetn = 1'b1;
    repeat (3) tick(1'b0);
    // continuous scan across two frame wraps
    repeat (2 * FRAME + 40) tick(1'b1);
    // alternating stall, long enough to cross another frame wrap
    for (int i = 0; i < 2 * FRAME + 40; i++) tick(i % 2 == 0);
    repeat (200) tick(1'($urandom_range(0, 1)));
    // reset partway through a line, then rescan from (0,0)
    repeat (7) tick(1'b1);
    async_reset();
    repeat (FRAME + 30) tick(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
